// File: rtl/nibble_add_seq.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit ripple slice, one nibble per clock, LSB first.
// Optional macro ADD_SEQ_SUB_EN adds a 'sub' port for a - b (two's complement via ~b + 1).

module fulladd4 (
    output logic [3:0] sum,
    output logic       c_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in
);
    logic [4:0] c;

    assign c[0] = c_in;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign c_out = c[4];
endmodule

module nibble_add_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef ADD_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int NNIB = WIDTH / 4;
    localparam int IW   = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NNIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic [WIDTH-1:0] sum_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic             carry_reg, carry_next;
    logic             sub_reg, sub_next;
    logic             busy_next, done_next, c_out_next;
    logic             sub_in;

`ifdef ADD_SEQ_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // Operand registers viewed as nibble arrays so the slice mux is a plain index.
    logic [3:0] a_nib [NNIB];
    logic [3:0] b_nib [NNIB];

    generate
        for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    logic [3:0] slice_a, slice_b, slice_sum;
    logic       slice_cout;

    assign slice_a = a_nib[idx_reg];
    assign slice_b = b_nib[idx_reg] ^ {4{sub_reg}};

    fulladd4 u_slice (
        .sum   (slice_sum),
        .c_out (slice_cout),
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_reg)
    );

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        result_next = result_reg;
        sum_next    = sum;
        idx_next    = idx_reg;
        carry_next  = carry_reg;
        sub_next    = sub_reg;
        c_out_next  = c_out;
        busy_next   = 1'b0;
        done_next   = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                // DONE accepts a new request exactly like IDLE, giving back-to-back issue.
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    sub_next   = sub_in;
                    carry_next = sub_in ? 1'b1 : c_in;
                    idx_next   = '0;
                    state_next = RUN;
                    busy_next  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < NNIB; i++) begin
                    if (idx_reg == IW'(i)) begin
                        result_next[4*i +: 4] = slice_sum;
                    end
                end
                carry_next = slice_cout;
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                    sum_next   = result_next;
                    c_out_next = slice_cout;
                    idx_next   = '0;
                end else begin
                    idx_next   = idx_reg + IW'(1);
                    busy_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            idx_reg    <= '0;
            carry_reg  <= 1'b0;
            sub_reg    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sum        <= '0;
            c_out      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            result_reg <= result_next;
            idx_reg    <= idx_next;
            carry_reg  <= carry_next;
            sub_reg    <= sub_next;
            busy       <= busy_next;
            done       <= done_next;
            sum        <= sum_next;
            c_out      <= c_out_next;
        end
    end
endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands using one shared 4-bit ripple adder slice (fulladd4: sum, c_out, a, b, c_in), instantiated inside this block.
- Processes one nibble per clock, LSB nibble first, and keeps the inter-nibble carry in a register.
- Trades latency for area when wide additions are needed; sits between a stimulus/control source and the adder datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NNIB, WIDTH/4, localparam (not overridable): number of nibble steps.

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request to begin an addition; sampled only when accepted (see Behaviour).
- a, input, WIDTH, operand A; latched when start is accepted.
- b, input, WIDTH, operand B; latched when start is accepted.
- c_in, input, 1, carry-in; latched when start is accepted.
- busy, output, 1, high while nibble steps are in progress.
- done, output, 1, single-cycle pulse when the result is valid.
- sum, output, WIDTH, registered result; holds its value until the next completion.
- c_out, output, 1, registered final carry-out; holds with sum.

Behaviour:
- FSM states: IDLE, RUN, DONE. State and all outputs are registered.
- Reset (synchronous, reset=1 at a rising edge): state=IDLE, busy=0, done=0, sum=0, c_out=0, nibble index=0, carry register=0, operand registers=0. Reset has priority over every other event.
- IDLE: if start=1, latch a, b and c_in (c_in goes into the carry register), set index=0, go to RUN, busy=1.
- RUN, each cycle:
  - Drive the slice with a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry register.
  - Write slice sum into result_reg[4*idx+:4]; write slice c_out into the carry register.
  - idx increments by 1.
  - When idx==NNIB-1, go to DONE and load sum<=result (including the final nibble) and c_out<=final carry.
- DONE: lasts exactly one cycle with done=1, busy=0.
  - If start=1 in DONE, the new operation is accepted exactly as in IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- start while busy=1 is ignored: no relatch and no queueing.
- Latency: start sampled at edge E0. busy is high for cycles E0+1 .. E0+NNIB. done is high in the cycle after edge E0+NNIB (for WIDTH=16, the 5th cycle after start).
- sum and c_out change only at the edge that enters DONE. They are stable throughout RUN and IDLE.
- Arithmetic: {c_out, sum} = a + b + c_in, modulo 2^(WIDTH+1); no truncation of the carry.
- Reset mid-RUN aborts the operation: no done pulse, and outputs return to their reset values.
- WIDTH=4 (NNIB=1): one RUN cycle, then DONE.

Optional Feature:
- Macro: ADD_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched together with start.
  - When sub=1, the b nibble fed to the slice is inverted and the initial carry is forced to 1; c_in is ignored.
  - Result: {c_out, sum} = a + ~b + 1, so c_out=1 means no borrow (a>=b).
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: the sub port does not exist and the block performs addition only.

Test Plan (WIDTH=16):
- Reset, then start with a=0x0003, b=0x0004, c_in=0 -> busy high for 4 cycles, done in the 5th cycle, sum=0x0007, c_out=0.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1 (carry ripples through all 4 nibbles). a=0x00A0, b=0x005F, c_in=1 -> sum=0x0100, c_out=0.
- Start 0x1234+0x1111; pulse start again 2 cycles later with 0xFFFF+0xFFFF -> exactly one done pulse, sum=0x2345, c_out=0, second request ignored.
- start held high in the done cycle with a=0x000A, b=0x0005 -> busy=1 on the next cycle, next done 5 cycles later with sum=0x000F; the previous sum is held until then.
- Assert reset during the 3rd RUN cycle -> next cycle busy=0, done=0, sum=0x0000, c_out=0; no done pulse follows.
- ADD_SEQ_SUB_EN defined: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0. sub=1, a=0x0009, b=0x0004 -> sum=0x0005, c_out=1.
